// File: rtl/frame_writer_if.sv
// Pixel stream from the video source into the frame writer: valid/ready
// handshake with start-of-frame and end-of-line qualifiers.
interface frame_writer_if;
  logic       pix_valid;
  logic [7:0] pix_data;
  logic       pix_sof;
  logic       pix_eol;
  logic       pix_ready;

  modport master (output pix_valid, pix_data, pix_sof, pix_eol, input pix_ready);
  modport slave  (input pix_valid, pix_data, pix_sof, pix_eol, output pix_ready);
endinterface

// File: rtl/frame_writer.sv
// Stores a raster pixel stream row-major into frame memory; writes appear one cycle after accept.
// Always ready except for the single DONE cycle after a frame completes.
module frame_writer #(
  parameter int MAX_W = 640,
  parameter int MAX_H = 480
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [9:0]         imageWidth,
  input  logic [8:0]         imageHeight,
  frame_writer_if.slave      pix,
  output logic               wr_en,
  output logic [18:0]        wr_addr,
  output logic [7:0]         wr_data,
  output logic               frame_done,
  output logic               frame_abort
);

  localparam logic [9:0] MAX_W_C = 10'(MAX_W);
  localparam logic [8:0] MAX_H_C = 9'(MAX_H);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t      state;
  logic [9:0]  col;
  logic [8:0]  row;
  logic [18:0] line_base;
  logic [9:0]  w_q;
  logic [8:0]  h_q;

  logic        accept;
  logic        start;
  logic        active;
  logic        write;
  logic        last_line;
  logic [9:0]  cur_w;
  logic [8:0]  cur_h;
  logic [9:0]  cur_col;
  logic [8:0]  cur_row;
  logic [18:0] cur_base;
  logic [9:0]  col_inc;
  logic [18:0] addr;

  assign pix.pix_ready = (state != DONE);

  // A sof pixel sees a freshly restarted frame, so its position is (0,0)
  // regardless of where the previous frame had got to.
  always_comb begin
    accept    = pix.pix_valid & pix.pix_ready;
    start     = accept & pix.pix_sof;
    active    = start | (accept & (state == WRITE));
    cur_w     = w_q;
    cur_h     = h_q;
    cur_col   = col;
    cur_row   = row;
    cur_base  = line_base;
    if (start) begin
      cur_w    = (imageWidth  > MAX_W_C) ? MAX_W_C : imageWidth;
      cur_h    = (imageHeight > MAX_H_C) ? MAX_H_C : imageHeight;
      cur_col  = '0;
      cur_row  = '0;
      cur_base = '0;
    end
    write     = active & (cur_col < cur_w) & (cur_row < cur_h);
    last_line = (cur_w == '0) | (cur_h == '0) | (cur_row == cur_h - 9'd1);
    col_inc   = (cur_col == 10'h3FF) ? cur_col : cur_col + 10'd1;
    addr      = cur_base + 19'(cur_col);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      col         <= '0;
      row         <= '0;
      line_base   <= '0;
      w_q         <= '0;
      h_q         <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      wr_en       <= write;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      if (write) begin
        wr_addr <= addr;
        wr_data <= pix.pix_data;
      end
      case (state)
        IDLE, WRITE: begin
          if (active) begin
            w_q         <= cur_w;
            h_q         <= cur_h;
            frame_abort <= start & (state == WRITE);
            if (pix.pix_eol) begin
              col       <= '0;
              row       <= cur_row + 9'd1;
              line_base <= cur_base + 19'(cur_w);
              state     <= last_line ? DONE : WRITE;
            end else begin
              col       <= col_inc;
              row       <= cur_row;
              line_base <= cur_base;
              state     <= WRITE;
            end
          end
        end
        DONE: begin
          state      <= IDLE;
          frame_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_writer.sv
// Directed bench for frame_writer with hand-computed expected addresses and pulses.
module tb_frame_writer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  image_width;
  logic [8:0]  image_height;
  logic        wr_en;
  logic [18:0] wr_addr;
  logic [7:0]  wr_data;
  logic        frame_done;
  logic        frame_abort;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  frame_writer_if pif ();

  frame_writer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imageWidth  (image_width),
    .imageHeight (image_height),
    .pix         (pif),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .frame_done  (frame_done),
    .frame_abort (frame_abort)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one beat, clock it, and return 1 time unit after the edge.
  task automatic step(input logic v, input logic [7:0] d, input logic s, input logic e);
    pif.pix_valid = v;
    pif.pix_data  = d;
    pif.pix_sof   = s;
    pif.pix_eol   = e;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input string tag, input logic en, input logic [18:0] a, input logic [7:0] d);
    check({tag, "_en"}, 32'(wr_en), 32'(en));
    if (en) begin
      check({tag, "_addr"}, 32'(wr_addr), 32'(a));
      check({tag, "_data"}, 32'(wr_data), 32'(d));
    end
  endtask

  initial begin
    int nw;
    logic [18:0] last_addr;

    pif.pix_valid = 1'b0;
    pif.pix_data  = '0;
    pif.pix_sof   = 1'b0;
    pif.pix_eol   = 1'b0;
    image_width   = 10'd4;
    image_height  = 9'd2;

    #12;
    check("rst_wr_en",   32'(wr_en), 32'd0);
    check("rst_addr",    32'(wr_addr), 32'd0);
    check("rst_data",    32'(wr_data), 32'd0);
    check("rst_done",    32'(frame_done), 32'd0);
    check("rst_abort",   32'(frame_abort), 32'd0);
    check("rst_ready",   32'(pif.pix_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'(8'hE0 + i), 1'b0, 1'b0);
      check("pre_sof_no_wr", 32'(wr_en), 32'd0);
    end

    // Two full lines of four.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'(8'h10 + i), i == 0, (i == 3) || (i == 7));
      expect_wr("full", 1'b1, 19'(i), 8'(8'h10 + i));
      check("full_no_done", 32'(frame_done), 32'd0);
    end
    check("done_not_ready", 32'(pif.pix_ready), 32'd0);
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    check("done_drop", 32'(wr_en), 32'd0);
    check("done_pulse", 32'(frame_done), 32'd1);
    check("idle_ready", 32'(pif.pix_ready), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("done_once", 32'(frame_done), 32'd0);

    // Long first line: pixels 5 and 6 are beyond the stored width.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 8'(8'h20 + i), i == 0, i == 5);
      expect_wr("long", i < 4, 19'(i), 8'(8'h20 + i));
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'(8'h30 + i), 1'b0, i == 3);
      expect_wr("long_l2", 1'b1, 19'(4 + i), 8'(8'h30 + i));
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("long_done", 32'(frame_done), 32'd1);

    // Short first line of two pixels.
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 8'(8'h40 + i), i == 0, i == 1);
      expect_wr("short", 1'b1, 19'(i), 8'(8'h40 + i));
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'(8'h48 + i), 1'b0, i == 3);
      expect_wr("short_l2", 1'b1, 19'(4 + i), 8'(8'h48 + i));
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("short_done", 32'(frame_done), 32'd1);

    // Restart mid-frame after three writes.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'(8'h50 + i), i == 0, 1'b0);
      expect_wr("pre_abort", 1'b1, 19'(i), 8'(8'h50 + i));
      check("pre_abort_flag", 32'(frame_abort), 32'd0);
    end
    step(1'b1, 8'h55, 1'b1, 1'b0);
    check("abort_pulse", 32'(frame_abort), 32'd1);
    expect_wr("abort_restart", 1'b1, 19'd0, 8'h55);
    step(1'b1, 8'h56, 1'b0, 1'b0);
    check("abort_once", 32'(frame_abort), 32'd0);
    expect_wr("abort_next", 1'b1, 19'd1, 8'h56);

    // Asynchronous reset while mid-frame with a write outstanding.
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_wr_en", 32'(wr_en), 32'd0);
    check("arst_addr",  32'(wr_addr), 32'd0);
    check("arst_data",  32'(wr_data), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("arst_ready", 32'(pif.pix_ready), 32'd1);
    step(1'b1, 8'h77, 1'b0, 1'b0);
    check("arst_discard", 32'(wr_en), 32'd0);

    // Zero width: nothing written, completes on first eol.
    image_width = 10'd0;
    step(1'b1, 8'h60, 1'b1, 1'b0);
    check("w0_sof", 32'(wr_en), 32'd0);
    step(1'b1, 8'h61, 1'b0, 1'b1);
    check("w0_eol", 32'(wr_en), 32'd0);
    check("w0_not_ready", 32'(pif.pix_ready), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("w0_done", 32'(frame_done), 32'd1);

    // sof and eol on one pixel of a single-row frame.
    image_width  = 10'd4;
    image_height = 9'd1;
    step(1'b1, 8'h99, 1'b1, 1'b1);
    expect_wr("sofeol", 1'b1, 19'd0, 8'h99);
    check("sofeol_not_ready", 32'(pif.pix_ready), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("sofeol_done", 32'(frame_done), 32'd1);

    // Oversized request clamps to 640x480; short lines keep the run brief.
    image_width  = 10'd700;
    image_height = 9'd500;
    step(1'b1, 8'h01, 1'b1, 1'b1);
    expect_wr("clamp_r0", 1'b1, 19'd0, 8'h01);
    for (int r = 1; r < 479; r++) begin
      step(1'b1, r[7:0], 1'b0, 1'b1);
      if (r == 1)   expect_wr("clamp_r1",   1'b1, 19'd640,    r[7:0]);
      if (r == 478) expect_wr("clamp_r478", 1'b1, 19'd305920, r[7:0]);
    end
    nw = 0;
    last_addr = '0;
    for (int c = 0; c < 700; c++) begin
      step(1'b1, c[7:0], 1'b0, c == 699);
      if (wr_en) begin
        nw++;
        last_addr = wr_addr;
      end
      if (c == 0) expect_wr("clamp_r479_first", 1'b1, 19'd306560, 8'h00);
    end
    check("clamp_row_writes", 32'(nw), 32'd640);
    check("clamp_last_addr", 32'(last_addr), 32'd307199);
    check("clamp_not_ready", 32'(pif.pix_ready), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("clamp_done", 32'(frame_done), 32'd1);
    nw = 0;
    for (int c = 0; c < 50; c++) begin
      step(1'b1, c[7:0], 1'b0, c == 49);
      if (wr_en) nw++;
    end
    check("clamp_no_extra_rows", 32'(nw), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
